// File: rtl/rv_isa_pkg.sv
// RV32 store-instruction constants and the packed S-type word layout shared by
// the instruction-generator blocks.
package rv_isa_pkg;

    localparam logic [6:0] OP_STORE = 7'b0100011;

    localparam logic [2:0] F3_SB = 3'b000;
    localparam logic [2:0] F3_SH = 3'b001;
    localparam logic [2:0] F3_SW = 3'b010;

    localparam int IMM_HI_MSB = 31;
    localparam int IMM_HI_LSB = 25;
    localparam int RS2_MSB    = 24;
    localparam int RS2_LSB    = 20;
    localparam int RS1_MSB    = 19;
    localparam int RS1_LSB    = 15;
    localparam int F3_MSB     = 14;
    localparam int F3_LSB     = 12;
    localparam int IMM_LO_MSB = 11;
    localparam int IMM_LO_LSB = 7;

    // Field order matches the bit positions above, MSB first.
    typedef struct packed {
        logic [6:0] imm_hi;
        logic [4:0] rs2;
        logic [4:0] rs1;
        logic [2:0] funct3;
        logic [4:0] imm_lo;
        logic [6:0] opcode;
    } s_word_t;

    function automatic logic f3_is_store(input logic [2:0] f3);
        return (f3 == F3_SB) || (f3 == F3_SH) || (f3 == F3_SW);
    endfunction

endpackage

// File: rtl/s_imm_split.sv
// Splits a 32-bit signed byte offset into the S-type immediate fields and flags
// offsets that do not fit a 12-bit signed immediate.
module s_imm_split (
    input  logic [31:0] offset,
    output logic [6:0]  imm_hi,
    output logic [4:0]  imm_lo,
    output logic        range_err
);

    assign imm_hi = offset[11:5];
    assign imm_lo = offset[4:0];

    // In range only when bits 31:11 are a pure sign extension of bit 11.
    assign range_err = ~((&offset[31:11]) | ~(|offset[31:11]));

endmodule

// File: rtl/s_imm_encoder.sv
// Two-stage valid/ready store-word encoder: S1 splits and checks the offset,
// S2 holds the assembled S-type word until downstream accepts it.
module s_imm_encoder
    import rv_isa_pkg::*;
#(
    parameter logic [6:0] OPCODE = OP_STORE,
    parameter int         CNT_W  = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      offset,
    input  logic [4:0]       rs1,
    input  logic [4:0]       rs2,
    input  logic [2:0]       funct3,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      instr,
    output logic [6:0]       imm7b,
    output logic [4:0]       imm5b,
    output logic [1:0]       err,
    output logic [CNT_W-1:0] word_cnt
);

    logic [6:0]       w_imm_hi;
    logic [4:0]       w_imm_lo;
    logic             w_range_err;
    logic             w_s1_load;
    logic             w_s2_load;
    s_word_t          w_word;

    logic             r_s1_v;
    logic [6:0]       r_s1_imm_hi;
    logic [4:0]       r_s1_imm_lo;
    logic [4:0]       r_s1_rs1;
    logic [4:0]       r_s1_rs2;
    logic [2:0]       r_s1_f3;
    logic [1:0]       r_s1_err;

    logic             r_s2_v;
    logic [31:0]      r_instr;
    logic [6:0]       r_imm7b;
    logic [4:0]       r_imm5b;
    logic [1:0]       r_err;
    logic [CNT_W-1:0] r_word_cnt;

    s_imm_split u_split (
        .offset    (offset),
        .imm_hi    (w_imm_hi),
        .imm_lo    (w_imm_lo),
        .range_err (w_range_err)
    );

    // in_ready looks through S2 so a full pipe can still stream at one word per cycle.
    assign w_s2_load = r_s1_v & (~r_s2_v | out_ready);
    assign in_ready  = ~r_s1_v | w_s2_load;
    assign w_s1_load = in_valid & in_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_s1_v      <= 1'b0;
            r_s1_imm_hi <= '0;
            r_s1_imm_lo <= '0;
            r_s1_rs1    <= '0;
            r_s1_rs2    <= '0;
            r_s1_f3     <= '0;
            r_s1_err    <= '0;
        end else begin
            if (w_s1_load) begin
                r_s1_v      <= 1'b1;
                r_s1_imm_hi <= w_imm_hi;
                r_s1_imm_lo <= w_imm_lo;
                r_s1_rs1    <= rs1;
                r_s1_rs2    <= rs2;
                r_s1_f3     <= funct3;
                r_s1_err    <= {~f3_is_store(funct3), w_range_err};
            end else if (w_s2_load) begin
                r_s1_v <= 1'b0;
            end
        end
    end

    always_comb begin
        w_word        = '0;
        w_word.imm_hi = r_s1_imm_hi;
        w_word.rs2    = r_s1_rs2;
        w_word.rs1    = r_s1_rs1;
        w_word.funct3 = r_s1_f3;
        w_word.imm_lo = r_s1_imm_lo;
        w_word.opcode = OPCODE;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_s2_v     <= 1'b0;
            r_instr    <= '0;
            r_imm7b    <= '0;
            r_imm5b    <= '0;
            r_err      <= '0;
            r_word_cnt <= '0;
        end else begin
            if (w_s2_load) begin
                r_s2_v  <= 1'b1;
                r_instr <= w_word;
                r_imm7b <= r_s1_imm_hi;
                r_imm5b <= r_s1_imm_lo;
                r_err   <= r_s1_err;
            end else if (out_ready) begin
                r_s2_v <= 1'b0;
            end
            // Saturating: error words are still handed off and therefore counted.
            if (r_s2_v && out_ready && (r_word_cnt != '1)) begin
                r_word_cnt <= r_word_cnt + CNT_W'(1);
            end
        end
    end

    assign out_valid = r_s2_v;
    assign instr     = r_instr;
    assign imm7b     = r_imm7b;
    assign imm5b     = r_imm5b;
    assign err       = r_err;
    assign word_cnt  = r_word_cnt;

endmodule

// File: tb/tb_s_imm_encoder.sv
// Scoreboard bench for s_imm_encoder: the driver pushes expected words, a separate
// monitor pops and compares on every output transfer.
module tb_s_imm_encoder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] offset;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  funct3;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] instr;
    logic [6:0]  imm7b;
    logic [4:0]  imm5b;
    logic [1:0]  err;
    logic [15:0] word_cnt;

    logic        in_ready_4;
    logic        out_valid_4;
    logic [31:0] instr_4;
    logic [6:0]  imm7b_4;
    logic [4:0]  imm5b_4;
    logic [1:0]  err_4;
    logic [3:0]  word_cnt_4;

    s_imm_encoder dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .offset(offset), .rs1(rs1), .rs2(rs2), .funct3(funct3),
        .out_valid(out_valid), .out_ready(out_ready), .instr(instr),
        .imm7b(imm7b), .imm5b(imm5b), .err(err), .word_cnt(word_cnt)
    );

    s_imm_encoder #(.CNT_W(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_4),
        .offset(offset), .rs1(rs1), .rs2(rs2), .funct3(funct3),
        .out_valid(out_valid_4), .out_ready(out_ready), .instr(instr_4),
        .imm7b(imm7b_4), .imm5b(imm5b_4), .err(err_4), .word_cnt(word_cnt_4)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] instr;
        logic [6:0]  imm7b;
        logic [4:0]  imm5b;
        logic [1:0]  err;
        int          acc_cyc;
        bit          lat;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;
    int   ready_mode = 0;   // 0: always ready, 1: never ready, 2: random
    bit   chk_lat  = 0;
    bit   nostall  = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input bit ok, input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: arithmetic on the offset value, independent of RTL structure.
    function automatic exp_t ref_model(input logic [31:0] off, input logic [4:0] r1,
                                       input logic [4:0] r2, input logic [2:0] f3);
        exp_t        e;
        logic [31:0] imm;
        int          so;
        so  = int'(off);
        imm = off % 32'd4096;
        e.imm7b  = 7'(imm / 32'd32);
        e.imm5b  = 5'(imm % 32'd32);
        e.instr  = (imm / 32'd32) * 32'h0200_0000 + 32'(r2) * 32'h0010_0000
                 + 32'(r1) * 32'h0000_8000 + 32'(f3) * 32'h0000_1000
                 + (imm % 32'd32) * 32'd128 + 32'h23;
        e.err[0] = (so < -2048) || (so > 2047);
        e.err[1] = (f3 > 3'd2);
        e.acc_cyc = 0;
        e.lat     = 0;
        return e;
    endfunction

    task automatic send_exp(input logic [31:0] off, input logic [4:0] r1, input logic [4:0] r2,
                            input logic [2:0] f3, input exp_t e);
        int waited = 0;
        @(negedge clk);
        in_valid = 1'b1; offset = off; rs1 = r1; rs2 = r2; funct3 = f3;
        forever begin
            #4;
            if (in_ready) break;
            waited++;
            if (waited > 200) begin
                check(1'b0, "accept_timeout", 64'(waited), 64'd200);
                return;
            end
            @(negedge clk);
        end
        if (nostall) check(waited == 0, "stream_stall", 64'(waited), 64'd0);
        e.acc_cyc = cyc;
        e.lat     = chk_lat;
        sb.push_back(e);
    endtask

    task automatic send(input logic [31:0] off, input logic [4:0] r1, input logic [4:0] r2,
                        input logic [2:0] f3);
        send_exp(off, r1, r2, f3, ref_model(off, r1, r2, f3));
    endtask

    task automatic idle();
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        idle();
        while (sb.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check(sb.size() == 0, "drain", 64'(sb.size()), 64'd0);
        repeat (2) @(negedge clk);
    endtask

    // Monitor: owns out_ready, compares every handoff and the word counters.
    initial begin
        int          tx = 0;
        int          rst_cyc = 0;
        bit          hold = 0;
        logic [46:0] held;
        exp_t        e;
        out_ready = 1'b1;
        forever begin
            @(negedge clk);
            case (ready_mode)
                0:       out_ready = 1'b1;
                1:       out_ready = 1'b0;
                default: out_ready = 1'($urandom_range(0, 1));
            endcase
            #4;
            if (!rst_n) begin
                if (rst_cyc > 0) begin
                    check(out_valid == 1'b0, "rst_out_valid", 64'(out_valid), 64'd0);
                    check(instr == 32'd0, "rst_instr", 64'(instr), 64'd0);
                    check(word_cnt == 16'd0, "rst_word_cnt", 64'(word_cnt), 64'd0);
                end
                rst_cyc++;
                tx   = 0;
                hold = 0;
            end else begin
                rst_cyc = 0;
                check(word_cnt == 16'((tx > 65535) ? 65535 : tx), "word_cnt", 64'(word_cnt), 64'(tx));
                check(word_cnt_4 == 4'((tx > 15) ? 15 : tx), "word_cnt_sat4", 64'(word_cnt_4),
                      64'((tx > 15) ? 15 : tx));
                if (hold)
                    check({out_valid, instr, imm7b, imm5b, err} == {1'b1, held[45:0]}, "hold_stable",
                          64'({out_valid, instr, imm7b, imm5b, err}), 64'({1'b1, held[45:0]}));
                if (out_valid && out_ready) begin
                    if (sb.size() == 0) begin
                        check(1'b0, "unexpected_word", 64'(instr), 64'd0);
                    end else begin
                        e = sb.pop_front();
                        check(instr == e.instr, "instr", 64'(instr), 64'(e.instr));
                        check(imm7b == e.imm7b, "imm7b", 64'(imm7b), 64'(e.imm7b));
                        check(imm5b == e.imm5b, "imm5b", 64'(imm5b), 64'(e.imm5b));
                        check(err == e.err, "err", 64'(err), 64'(e.err));
                        if (e.lat)
                            check(cyc - e.acc_cyc == 2, "latency", 64'(cyc - e.acc_cyc), 64'd2);
                    end
                    tx++;
                end
                hold = out_valid && !out_ready;
                held = {out_valid, instr, imm7b, imm5b, err};
            end
        end
    end

    initial begin
        exp_t e;
        rst_n = 1'b0; in_valid = 1'b1; offset = 32'h1234_5678; rs1 = 5'd1; rs2 = 5'd2; funct3 = 3'd2;
        repeat (2) @(negedge clk);
        #4;
        check(out_valid == 1'b0, "reset_out_valid", 64'(out_valid), 64'd0);
        check(instr == 32'd0, "reset_instr", 64'(instr), 64'd0);
        check(word_cnt == 16'd0, "reset_word_cnt", 64'(word_cnt), 64'd0);
        @(negedge clk);
        rst_n = 1'b1; in_valid = 1'b0;
        repeat (3) @(negedge clk);
        #4;
        check(out_valid == 1'b0, "reset_no_transfer", 64'(out_valid), 64'd0);

        // Known words and error flags, expectations written out by hand.
        chk_lat = 1;
        e = '{instr: 32'hFE512E23, imm7b: 7'h7F, imm5b: 5'h1C, err: 2'b00, acc_cyc: 0, lat: 0};
        send_exp(32'hFFFF_FFFC, 5'd2, 5'd5, 3'b010, e);
        drain();
        e = '{instr: 32'h00B50423, imm7b: 7'h00, imm5b: 5'h08, err: 2'b00, acc_cyc: 0, lat: 0};
        send_exp(32'd8, 5'd10, 5'd11, 3'b000, e);
        e = '{instr: 32'h80208023, imm7b: 7'h40, imm5b: 5'h00, err: 2'b01, acc_cyc: 0, lat: 0};
        send_exp(32'd2048, 5'd1, 5'd2, 3'b000, e);
        e = '{instr: 32'h7E002FA3, imm7b: 7'h3F, imm5b: 5'h1F, err: 2'b01, acc_cyc: 0, lat: 0};
        send_exp(32'hFFFF_F7FF, 5'd0, 5'd0, 3'b010, e);
        e = '{instr: 32'h0041B023, imm7b: 7'h00, imm5b: 5'h00, err: 2'b10, acc_cyc: 0, lat: 0};
        send_exp(32'd0, 5'd3, 5'd4, 3'b011, e);
        send(32'd2047, 5'd31, 5'd31, 3'b001);
        send(32'hFFFF_F800, 5'd7, 5'd9, 3'b111);
        drain();
        chk_lat = 0;

        // Backpressure: two accepts fill the pipe, the third must wait.
        ready_mode = 1;
        @(negedge clk);
        send(32'd100, 5'd1, 5'd2, 3'd0);
        send(32'd200, 5'd3, 5'd4, 3'd1);
        @(negedge clk);
        offset = 32'hFFFF_FF00; rs1 = 5'd5; rs2 = 5'd6; funct3 = 3'd2; in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #4;
            check(in_ready == 1'b0, "bp_in_ready", 64'(in_ready), 64'd0);
            check(out_valid == 1'b1, "bp_out_valid", 64'(out_valid), 64'd1);
            @(negedge clk);
        end
        ready_mode = 0;
        #4;
        sb.push_back(ref_model(32'hFFFF_FF00, 5'd5, 5'd6, 3'd2));
        drain();

        // Reset with two words in flight: both are discarded.
        ready_mode = 1;
        send(32'd12, 5'd1, 5'd1, 3'd0);
        send(32'd16, 5'd2, 5'd2, 3'd1);
        @(negedge clk);
        in_valid = 1'b0; rst_n = 1'b0;
        sb.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1; ready_mode = 0;
        #4;
        check(word_cnt == 16'd0, "midrst_word_cnt", 64'(word_cnt), 64'd0);
        check(out_valid == 1'b0, "midrst_out_valid", 64'(out_valid), 64'd0);
        chk_lat = 1;
        send(32'd44, 5'd8, 5'd9, 3'd2);
        drain();

        // Streaming: back-to-back random words at full rate (count continues from 1).
        nostall = 1;
        for (int i = 0; i < 99; i++)
            send($urandom, 5'($urandom), 5'($urandom), 3'($urandom_range(0, 2)));
        nostall = 0;
        drain();
        chk_lat = 0;
        #4;
        check(word_cnt == 16'd100, "stream_word_cnt", 64'(word_cnt), 64'd100);
        check(word_cnt_4 == 4'hF, "sat_word_cnt4", 64'(word_cnt_4), 64'hF);

        // Random out_ready and input gaps against the reference model.
        ready_mode = 2;
        for (int i = 0; i < 300; i++) begin
            logic [31:0] off;
            off = ($urandom_range(0, 1) == 1) ? 32'($urandom)
                                              : (32'($urandom_range(0, 6000)) - 32'd3000);
            if ($urandom_range(0, 3) == 0) idle();
            send(off, 5'($urandom), 5'($urandom), 3'($urandom_range(0, 7)));
        end
        ready_mode = 0;
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "timeout");
    end

endmodule
